instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder: packs request fields into a 32-bit word, writes it to instruction memory.
// Latency: word registered one cycle after handshake; in_ready drops in WRITE, when full, or during flush.
`timescale 1ns/1ps

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        flush,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        full,
  output logic        err_illegal,
  output logic [8:0]  word_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [5:0] op;
  } op_lookup_t;

  localparam logic [4:0] K_RTYPE   = 5'd0;
  localparam logic [4:0] K_LUI     = 5'd7;
  localparam logic [4:0] K_J       = 5'd18;
  localparam logic [4:0] K_JAL     = 5'd19;
  localparam logic [8:0] DEPTH_CNT = 9'(DEPTH);

  state_t      state_q, state_d;
  logic [8:0]  word_count_q, word_count_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_illegal_q, err_illegal_d;

  op_lookup_t  lookup;
  logic [31:0] enc_word;
  logic [31:0] next_addr;
  logic        accept;

  function automatic op_lookup_t lookup_op(input logic [4:0] kind);
    op_lookup_t r;
    r.legal = 1'b1;
    r.op    = 6'b000000;
    case (kind)
      5'd0:    r.op = 6'b000000;
      5'd1:    r.op = 6'b001000;
      5'd2:    r.op = 6'b001001;
      5'd3:    r.op = 6'b001101;
      5'd4:    r.op = 6'b001100;
      5'd5:    r.op = 6'b001010;
      5'd6:    r.op = 6'b001011;
      5'd7:    r.op = 6'b001111;
      5'd8:    r.op = 6'b100011;
      5'd9:    r.op = 6'b101011;
      5'd10:   r.op = 6'b100001;
      5'd11:   r.op = 6'b100101;
      5'd12:   r.op = 6'b100000;
      5'd13:   r.op = 6'b100100;
      5'd14:   r.op = 6'b101000;
      5'd15:   r.op = 6'b101001;
      5'd16:   r.op = 6'b000100;
      5'd17:   r.op = 6'b000101;
      5'd18:   r.op = 6'b000010;
      5'd19:   r.op = 6'b000011;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    lookup = lookup_op(in_kind);
    case (in_kind)
      K_RTYPE:    enc_word = {lookup.op, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_J, K_JAL: enc_word = {lookup.op, in_target};
      K_LUI:      enc_word = {lookup.op, 5'b00000, in_rt, in_imm};
      default:    enc_word = {lookup.op, in_rs, in_rt, in_imm};
    endcase
  end

  assign next_addr = BASE_ADDR + {21'b0, word_count_q, 2'b00};
  assign full      = (word_count_q == DEPTH_CNT);
  assign in_ready  = (state_q == IDLE) && !full && !flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        // flush wins over a simultaneous request because in_ready is already low
        if (flush) begin
          word_count_d = 9'd0;
        end else if (accept) begin
          if (lookup.legal) begin
            mem_wdata_d = enc_word;
            mem_addr_d  = next_addr;
            state_d     = WRITE;
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          word_count_d = word_count_q + 9'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      word_count_q  <= 9'd0;
      mem_addr_q    <= BASE_ADDR;
      mem_wdata_q   <= 32'd0;
      err_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_illegal_q <= err_illegal_d;
    end
  end

  assign mem_we      = (state_q == WRITE);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_illegal = err_illegal_q;
  assign word_count  = word_count_q;

endmodule
